// File: rtl/lcd_msg_display.sv
// HD44780 16x4 character-LCD refresh engine: power-up, init, then endless scan-out of the 64-byte dispMsg snapshot.
// Optional build macro LCD_MSG_ASCII_FILTER_EN replaces non-printable character bytes with a space.
module lcd_msg_display #(
    parameter int unsigned T_PWR = 1000000,
    parameter int unsigned T_EN  = 50,
    parameter int unsigned T_CMD = 2500,
    parameter int unsigned T_CLR = 100000
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [0:511] dispMsg,
    output logic [7:0]   LCD_DATA,
    output logic         LCD_RS,
    output logic         LCD_RW,
    output logic         LCD_E,
    output logic         busy,
    output logic         frame_done
);
    localparam int unsigned T_M0  = (T_PWR > T_EN) ? T_PWR : T_EN;
    localparam int unsigned T_M1  = (T_CMD > T_CLR) ? T_CMD : T_CLR;
    localparam int unsigned T_MAX = (T_M0 > T_M1) ? T_M0 : T_M1;
    localparam int unsigned CW    = $clog2(T_MAX + 2);

    localparam logic [CW-1:0] C_PWR = CW'(T_PWR);
    localparam logic [CW-1:0] C_EN  = CW'(T_EN);
    localparam logic [CW-1:0] C_CMD = CW'(T_CMD);
    localparam logic [CW-1:0] C_CLR = CW'(T_CLR);

    localparam logic [2:0] PWR_WAIT    = 3'd0;
    localparam logic [2:0] INIT        = 3'd1;
    localparam logic [2:0] FRAME_LATCH = 3'd2;
    localparam logic [2:0] ROW_ADDR    = 3'd3;
    localparam logic [2:0] CHAR        = 3'd4;

    localparam logic [1:0] SETUP  = 2'd0;
    localparam logic [1:0] STROBE = 2'd1;
    localparam logic [1:0] HOLD   = 2'd2;

    logic [2:0]    r_state;
    logic [1:0]    r_phase;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_init_idx;
    logic [1:0]    r_row;
    logic [3:0]    r_col;
    logic [0:511]  r_snap;
    logic [7:0]    r_lcd_data;
    logic          r_lcd_rs;
    logic          r_lcd_e;
    logic          r_busy;
    logic          r_frame_done;

    logic [2:0]    w_state_n;
    logic [1:0]    w_phase_n;
    logic [CW-1:0] w_cnt_n;
    logic [CW-1:0] w_cnt_inc;
    logic [CW-1:0] w_hold_len;
    logic [1:0]    w_init_idx_n;
    logic [1:0]    w_row_n;
    logic [3:0]    w_col_n;
    logic [7:0]    w_data_n;
    logic          w_rs_n;
    logic          w_e_n;
    logic          w_busy_n;
    logic          w_fd_n;
    logic          w_latch;
    logic          w_start;
    logic [7:0]    w_start_byte;
    logic          w_start_rs;
    logic          w_last_char;
    logic [5:0]    w_char_idx;
    logic [7:0]    w_raw_char;
    logic [7:0]    w_char;

    function automatic logic [7:0] f_init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    function automatic logic [7:0] f_row_cmd(input logic [1:0] row);
        case (row)
            2'd0:    return 8'h80;
            2'd1:    return 8'hC0;
            2'd2:    return 8'h90;
            default: return 8'hD0;
        endcase
    endfunction

    assign w_cnt_inc   = r_cnt + 1'b1;
    assign w_hold_len  = (r_state == INIT && r_init_idx == 2'd3) ? C_CLR : C_CMD;
    assign w_last_char = (r_state == CHAR) && (r_row == 2'd3) && (r_col == 4'd15);
    // Index of the character that starts next: column 0 after a row address, else the following column.
    assign w_char_idx  = {r_row, (r_state == CHAR) ? (r_col + 4'd1) : 4'd0};
    assign w_raw_char  = r_snap[{w_char_idx, 3'b000} +: 8];

`ifdef LCD_MSG_ASCII_FILTER_EN
    assign w_char = (w_raw_char < 8'h20 || w_raw_char > 8'h7E) ? 8'h20 : w_raw_char;
`else
    assign w_char = w_raw_char;
`endif

    always_comb begin
        w_state_n    = r_state;
        w_phase_n    = r_phase;
        w_cnt_n      = w_cnt_inc;
        w_init_idx_n = r_init_idx;
        w_row_n      = r_row;
        w_col_n      = r_col;
        w_data_n     = r_lcd_data;
        w_rs_n       = r_lcd_rs;
        w_e_n        = r_lcd_e;
        w_busy_n     = r_busy;
        w_fd_n       = 1'b0;
        w_latch      = 1'b0;
        w_start      = 1'b0;
        w_start_byte = '0;
        w_start_rs   = 1'b0;
        case (r_state)
            PWR_WAIT: begin
                if (r_cnt == C_PWR) begin
                    w_state_n    = INIT;
                    w_init_idx_n = 2'd0;
                    w_start      = 1'b1;
                    w_start_byte = f_init_cmd(2'd0);
                end
            end
            FRAME_LATCH: begin
                w_latch      = 1'b1;
                w_state_n    = ROW_ADDR;
                w_row_n      = 2'd0;
                w_start      = 1'b1;
                w_start_byte = f_row_cmd(2'd0);
            end
            default: begin
                case (r_phase)
                    SETUP: begin
                        w_phase_n = STROBE;
                        w_e_n     = 1'b1;
                        w_cnt_n   = CW'(1);
                    end
                    STROBE: begin
                        if (r_cnt == C_EN) begin
                            w_phase_n = HOLD;
                            w_e_n     = 1'b0;
                            w_cnt_n   = CW'(1);
                            w_fd_n    = w_last_char && (w_hold_len == CW'(1));
                        end
                    end
                    default: begin
                        if (r_cnt != w_hold_len) begin
                            // frame_done must be visible in the final HOLD cycle, so raise it one edge early
                            w_fd_n = w_last_char && (w_cnt_inc == w_hold_len);
                        end else begin
                            case (r_state)
                                INIT: begin
                                    if (r_init_idx == 2'd3) begin
                                        w_state_n = FRAME_LATCH;
                                        w_busy_n  = 1'b0;
                                    end else begin
                                        w_init_idx_n = r_init_idx + 2'd1;
                                        w_start      = 1'b1;
                                        w_start_byte = f_init_cmd(r_init_idx + 2'd1);
                                    end
                                end
                                ROW_ADDR: begin
                                    w_state_n    = CHAR;
                                    w_col_n      = 4'd0;
                                    w_start      = 1'b1;
                                    w_start_byte = w_char;
                                    w_start_rs   = 1'b1;
                                end
                                default: begin
                                    if (r_col == 4'd15) begin
                                        if (r_row == 2'd3) begin
                                            w_state_n = FRAME_LATCH;
                                        end else begin
                                            w_state_n    = ROW_ADDR;
                                            w_row_n      = r_row + 2'd1;
                                            w_start      = 1'b1;
                                            w_start_byte = f_row_cmd(r_row + 2'd1);
                                        end
                                    end else begin
                                        w_col_n      = r_col + 4'd1;
                                        w_start      = 1'b1;
                                        w_start_byte = w_char;
                                        w_start_rs   = 1'b1;
                                    end
                                end
                            endcase
                        end
                    end
                endcase
            end
        endcase
        if (w_start) begin
            w_phase_n = SETUP;
            w_cnt_n   = '0;
            w_data_n  = w_start_byte;
            w_rs_n    = w_start_rs;
            w_e_n     = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state      <= PWR_WAIT;
            r_phase      <= SETUP;
            r_cnt        <= '0;
            r_init_idx   <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_lcd_data   <= '0;
            r_lcd_rs     <= 1'b0;
            r_lcd_e      <= 1'b0;
            r_busy       <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_phase      <= w_phase_n;
            r_cnt        <= w_cnt_n;
            r_init_idx   <= w_init_idx_n;
            r_row        <= w_row_n;
            r_col        <= w_col_n;
            r_lcd_data   <= w_data_n;
            r_lcd_rs     <= w_rs_n;
            r_lcd_e      <= w_e_n;
            r_busy       <= w_busy_n;
            r_frame_done <= w_fd_n;
        end
    end

    // Snapshot deliberately survives reset; the next FRAME_LATCH overwrites it.
    always_ff @(posedge CLK) begin
        if (w_latch && !RESET) begin
            r_snap <= dispMsg;
        end
    end

    assign LCD_DATA   = r_lcd_data;
    assign LCD_RS     = r_lcd_rs;
    assign LCD_RW     = 1'b0;
    assign LCD_E      = r_lcd_e;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_lcd_msg_display.sv
// Self-checking bench for lcd_msg_display: transfer-level reference model of init, frame scan-out and reset behaviour.
module tb_lcd_msg_display;
    localparam int T_PWR     = 10;
    localparam int T_EN      = 2;
    localparam int T_CMD     = 4;
    localparam int T_CLR     = 8;
    localparam int XFER      = 1 + T_EN + T_CMD;
    localparam int INIT_END  = T_PWR + 4 * (1 + T_EN) + 3 * T_CMD + T_CLR;
    localparam int FRAME_LEN = 1 + 68 * XFER;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic [0:511] dispMsg;
    logic [7:0]   LCD_DATA;
    logic         LCD_RS;
    logic         LCD_RW;
    logic         LCD_E;
    logic         busy;
    logic         frame_done;

    lcd_msg_display #(
        .T_PWR(T_PWR),
        .T_EN (T_EN),
        .T_CMD(T_CMD),
        .T_CLR(T_CLR)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .dispMsg   (dispMsg),
        .LCD_DATA  (LCD_DATA),
        .LCD_RS    (LCD_RS),
        .LCD_RW    (LCD_RW),
        .LCD_E     (LCD_E),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 CLK = ~CLK;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = -100;
    logic [7:0] cur_msg  [64];
    logic [7:0] next_msg [64];
    logic [7:0] frame_msg[64];
    logic       e_prev;
    logic       busy_prev;
    logic       rs_prev;
    logic [7:0] d_prev;
    logic [7:0] d_rise;
    logic       rs_rise;
    int         e_len;
    bit         rose;
    bit         chk_pulse;
    int         busy_fall;
    int         fd_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    function automatic logic [7:0] init_cmd(input int i);
        case (i)
            0:       return 8'h38;
            1:       return 8'h0C;
            2:       return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    function automatic logic [7:0] row_cmd(input int r);
        case (r)
            0:       return 8'h80;
            1:       return 8'hC0;
            2:       return 8'h90;
            default: return 8'hD0;
        endcase
    endfunction

    function automatic logic [7:0] exp_char(input logic [7:0] b);
`ifdef LCD_MSG_ASCII_FILTER_EN
        return (b < 8'h20 || b > 8'h7E) ? 8'h20 : b;
`else
        return b;
`endif
    endfunction

    // Byte k lives at bits 8k..8k+7 with bit 8k the MSB.
    task automatic drive_msg();
        for (int k = 0; k < 64; k++)
            for (int b = 0; b < 8; b++)
                dispMsg[8 * k + b] = cur_msg[k][7 - b];
    endtask

    task automatic step();
        e_prev    = LCD_E;
        busy_prev = busy;
        d_prev    = LCD_DATA;
        rs_prev   = LCD_RS;
        @(negedge CLK);
        cyc++;
        if (busy_prev && !busy) busy_fall = cyc;
        if (frame_done) fd_q.push_back(cyc);
        if (LCD_E && !e_prev) begin
            rose    = 1'b1;
            e_len   = 1;
            d_rise  = LCD_DATA;
            rs_rise = LCD_RS;
            chk("setup_stable", {rs_prev, d_prev}, {LCD_RS, LCD_DATA});
            chk("rw_low", LCD_RW, 0);
        end else if (LCD_E) begin
            e_len++;
        end else if (e_prev && chk_pulse) begin
            chk("e_width", e_len, T_EN);
            chk("hold_stable", {LCD_RS, LCD_DATA}, {rs_rise, d_rise});
        end
    endtask

    task automatic next_xfer(output int t, output logic [7:0] d, output logic rs);
        rose = 1'b0;
        for (int i = 0; i < 64 && !rose; i++) step();
        chk("xfer_seen", rose, 1);
        t  = cyc;
        d  = LCD_DATA;
        rs = LCD_RS;
    endtask

    task automatic check_frame(input int f, input int chg_j, input int rst_j);
        int         t;
        logic [7:0] d;
        logic       rs;
        int         row;
        int         pos;
        frame_msg = cur_msg;
        fd_q.delete();
        for (int j = 0; j < 68; j++) begin
            next_xfer(t, d, rs);
            row = j / 17;
            pos = j % 17;
            chk("xfer_time", t, f + 2 + j * XFER);
            if (pos == 0) begin
                chk("row_cmd", d, row_cmd(row));
                chk("row_rs", rs, 0);
            end else begin
                chk("char_data", d, exp_char(frame_msg[row * 16 + pos - 1]));
                chk("char_rs", rs, 1);
            end
            if (j == chg_j) begin
                cur_msg = next_msg;
                drive_msg();
            end
            if (j == rst_j) return;
        end
        while (cyc < f + FRAME_LEN) step();
        chk("frame_done_count", fd_q.size(), 1);
        if (fd_q.size() > 0) chk("frame_done_cycle", fd_q[0], f + FRAME_LEN - 1);
        chk("busy_in_frame", busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int         t;
        int         f;
        int         e_hi;
        logic [7:0] d;
        logic       rs;

        for (int k = 0; k < 64; k++) cur_msg[k] = 8'h31;
        drive_msg();
        chk_pulse = 1'b1;
        busy_fall = -1;
        e_prev    = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_data", LCD_DATA, 8'h00);
        chk("rst_rs", LCD_RS, 0);
        chk("rst_rw", LCD_RW, 0);
        chk("rst_e", LCD_E, 0);
        chk("rst_busy", busy, 1);
        chk("rst_frame_done", frame_done, 0);

        RESET = 1'b0;
        cyc   = -1;
        for (int i = 0; i < 4; i++) begin
            next_xfer(t, d, rs);
            chk("init_time", t, T_PWR + 1 + i * XFER);
            chk("init_cmd", d, init_cmd(i));
            chk("init_rs", rs, 0);
        end
        while (cyc < INIT_END) step();
        chk("busy_fall", busy_fall, INIT_END);

        f = INIT_END;
        for (int k = 0; k < 64; k++) next_msg[k] = 8'h32;
        check_frame(f, 6, -1);

        f += FRAME_LEN;
        for (int k = 0; k < 64; k++) next_msg[k] = 8'(k + 8'h40);
        check_frame(f, 30, -1);

        f += FRAME_LEN;
        for (int k = 0; k < 64; k++) next_msg[k] = 8'($urandom_range(0, 255));
        next_msg[0] = 8'hA0;
        check_frame(f, 40, -1);

        f += FRAME_LEN;
        for (int k = 0; k < 64; k++) next_msg[k] = 8'($urandom_range(0, 255));
        check_frame(f, 50, -1);

        f += FRAME_LEN;
        check_frame(f, -1, 22);
        chk("pre_reset_e", LCD_E, 1);
        RESET     = 1'b1;
        chk_pulse = 1'b0;
        step();
        chk("midrst_e", LCD_E, 0);
        chk("midrst_data", LCD_DATA, 8'h00);
        chk("midrst_rs", LCD_RS, 0);
        chk("midrst_busy", busy, 1);
        chk("midrst_frame_done", frame_done, 0);
        RESET = 1'b0;
        cyc   = -1;
        e_hi  = 0;
        while (cyc < T_PWR) begin
            step();
            if (LCD_E) e_hi++;
        end
        chk("pwr_wait_e_low", e_hi, 0);
        chk("reinit_setup_data", LCD_DATA, 8'h38);
        chk("reinit_setup_rs", LCD_RS, 0);
        chk("reinit_busy", busy, 1);
        chk_pulse = 1'b1;
        next_xfer(t, d, rs);
        chk("reinit_rise", t, T_PWR + 1);
        chk("reinit_cmd", d, 8'h38);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
